// File: rtl/pacman_life_ctrl.sv
// Pac-Man HP/lives tracker with a freeze -> shield -> play respawn sequence.
// Latency: every output is registered and reflects the inputs sampled on the previous edge.
// Backpressure: none; the inputs are single-cycle events that are consumed or ignored on the cycle they arrive.
//
// Ports:
//   clk_i, reset_i       clock and synchronous active-high reset
//   startOfFrame_i       one-cycle pulse per video frame; drives the FREEZE/SHIELD counter
//   newGame_i            restart request; reloads HP and lives and returns to PLAY
//   addHP_i, removeHP_i  HP delta for this cycle from the monster arbitration stage
//   pacmanRespawn_i      collision event for this cycle
//   hp_o, lives_o        current HP pool and remaining lives
//   respawnPulse_o       one-cycle command to move Pac-Man to the start tile
//   freezePlay_o         movement frozen (FREEZE and GAME_OVER)
//   shieldOn_o           invulnerable window (SHIELD)
//   gameOver_o           GAME_OVER state
module pacman_life_ctrl #(
    parameter int HP_MAX        = 31,
    parameter int HP_INIT       = 16,
    parameter int LIVES_INIT    = 3,
    parameter int FREEZE_FRAMES = 64,
    parameter int SHIELD_FRAMES = 128
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       startOfFrame_i,
    input  logic       newGame_i,
    input  logic [4:0] addHP_i,
    input  logic [4:0] removeHP_i,
    input  logic       pacmanRespawn_i,
    output logic [4:0] hp_o,
    output logic [2:0] lives_o,
    output logic       respawnPulse_o,
    output logic       freezePlay_o,
    output logic       shieldOn_o,
    output logic       gameOver_o
);

    typedef enum logic [1:0] {
        ST_PLAY      = 2'd0,
        ST_FREEZE    = 2'd1,
        ST_SHIELD    = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  hp_q, hp_d;
    logic [2:0]  lives_q, lives_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pulse_q, pulse_d;
    logic        freeze_q, freeze_d;
    logic        shield_q, shield_d;
    logic        over_q, over_d;

    logic [4:0]        add_eff;
    logic [4:0]        rem_eff;
    logic signed [6:0] hp_t;
    logic [4:0]        hp_sat;
    logic [8:0]        cnt_inc;
    logic [2:0]        lives_dec;

    // HP inputs are masked per state before the arithmetic, so a single
    // saturating adder serves every state.
    always_comb begin
        add_eff = 5'd0;
        rem_eff = 5'd0;
        case (state_q)
            ST_PLAY: begin
                add_eff = addHP_i;
                rem_eff = removeHP_i;
            end
            ST_SHIELD: begin
                add_eff = addHP_i;
            end
            default: begin
                add_eff = 5'd0;
                rem_eff = 5'd0;
            end
        endcase
    end

    // Add and remove are netted in 7-bit signed space before clamping, so a
    // same-cycle add cannot saturate on its own before the remove lands.
    always_comb begin
        hp_t = $signed({2'b00, hp_q}) + $signed({2'b00, add_eff})
             - $signed({2'b00, rem_eff});
        if (hp_t < 7'sd0) begin
            hp_sat = 5'd0;
        end else if (hp_t > $signed(7'(HP_MAX))) begin
            hp_sat = 5'(HP_MAX);
        end else begin
            hp_sat = hp_t[4:0];
        end
    end

    assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
    assign lives_dec = lives_q - 3'd1;

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;

        if (newGame_i) begin
            state_d = ST_PLAY;
            hp_d    = 5'(HP_INIT);
            lives_d = 3'(LIVES_INIT);
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    hp_d = hp_sat;
                    if (pacmanRespawn_i) begin
                        lives_d = lives_dec;
                        if (lives_dec == 3'd0 || hp_sat == 5'd0) begin
                            state_d = ST_GAME_OVER;
                        end else begin
                            state_d = ST_FREEZE;
                            cnt_d   = 8'd0;
                            pulse_d = 1'b1;
                        end
                    end else if (hp_sat == 5'd0) begin
                        state_d = ST_GAME_OVER;
                    end
                end
                ST_FREEZE: begin
                    if (startOfFrame_i) begin
                        if (cnt_inc == 9'(FREEZE_FRAMES)) begin
                            state_d = ST_SHIELD;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = cnt_inc[7:0];
                        end
                    end
                end
                ST_SHIELD: begin
                    hp_d = hp_sat;
                    if (startOfFrame_i) begin
                        if (cnt_inc == 9'(SHIELD_FRAMES)) begin
                            state_d = ST_PLAY;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = cnt_inc[7:0];
                        end
                    end
                end
                default: begin
                    state_d = ST_GAME_OVER;
                end
            endcase
        end

        // Flags are decoded from the next state so they line up with the
        // registered state rather than trailing it by a cycle.
        freeze_d = (state_d == ST_FREEZE) || (state_d == ST_GAME_OVER);
        shield_d = (state_d == ST_SHIELD);
        over_d   = (state_d == ST_GAME_OVER);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_PLAY;
            hp_q     <= 5'(HP_INIT);
            lives_q  <= 3'(LIVES_INIT);
            cnt_q    <= 8'd0;
            pulse_q  <= 1'b0;
            freeze_q <= 1'b0;
            shield_q <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hp_q     <= hp_d;
            lives_q  <= lives_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            freeze_q <= freeze_d;
            shield_q <= shield_d;
            over_q   <= over_d;
        end
    end

    assign hp_o           = hp_q;
    assign lives_o        = lives_q;
    assign respawnPulse_o = pulse_q;
    assign freezePlay_o   = freeze_q;
    assign shieldOn_o     = shield_q;
    assign gameOver_o     = over_q;

endmodule

// File: tb/tb_pacman_life_ctrl.sv
// Directed-vector bench for pacman_life_ctrl with a queued scoreboard.
// Latency: each driven cycle's expected outputs are checked one clock later.
// Backpressure: none; one expectation is queued and retired per cycle.
module tb_pacman_life_ctrl;

    localparam logic [3:0] FL_IDLE = 4'b0000;
    localparam logic [3:0] FL_RESP = 4'b1100;
    localparam logic [3:0] FL_FRZ  = 4'b0100;
    localparam logic [3:0] FL_SHLD = 4'b0010;
    localparam logic [3:0] FL_GO   = 4'b0101;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sof = 1'b0;
    logic       ng = 1'b0;
    logic [4:0] add = 5'd0;
    logic [4:0] rem = 5'd0;
    logic       resp = 1'b0;
    logic [4:0] hp;
    logic [2:0] lives;
    logic       pulse, frz, shld, over;

    typedef struct {
        int         due;
        int         ph;
        logic [4:0] hp;
        logic [2:0] lv;
        logic [3:0] fl;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   phase = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    pacman_life_ctrl dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .startOfFrame_i  (sof),
        .newGame_i       (ng),
        .addHP_i         (add),
        .removeHP_i      (rem),
        .pacmanRespawn_i (resp),
        .hp_o            (hp),
        .lives_o         (lives),
        .respawnPulse_o  (pulse),
        .freezePlay_o    (frz),
        .shieldOn_o      (shld),
        .gameOver_o      (over)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of inputs and queue what the outputs must be after the next edge.
    task automatic step(input logic s_sof, input logic s_ng, input logic s_rst,
                        input logic s_resp, input logic [4:0] s_add, input logic [4:0] s_rem,
                        input logic [4:0] e_hp, input logic [2:0] e_lv, input logic [3:0] e_fl);
        exp_t e;
        @(negedge clk);
        sof   = s_sof;
        ng    = s_ng;
        reset = s_rst;
        resp  = s_resp;
        add   = s_add;
        rem   = s_rem;
        e.due = cyc + 1;
        e.ph  = phase;
        e.hp  = e_hp;
        e.lv  = e_lv;
        e.fl  = e_fl;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [4:0] e_hp, input logic [2:0] e_lv,
                        input logic [3:0] e_fl);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 5'd0, 5'd0, e_hp, e_lv, e_fl);
    endtask

    // n frame pulses; the last one is the one that changes state.
    task automatic frames(input int n, input logic [4:0] e_hp, input logic [2:0] e_lv,
                          input logic [3:0] fl_during, input logic [3:0] fl_end);
        for (int i = 1; i <= n; i++)
            step(1, 0, 0, 0, 5'd0, 5'd0, e_hp, e_lv, (i == n) ? fl_end : fl_during);
    endtask

    // Monitor: retires the expectation due at this cycle.
    initial begin
        exp_t e;
        logic [3:0] got_fl;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                got_fl = {pulse, frz, shld, over};
                n_chk++;
                if (hp !== e.hp || lives !== e.lv || got_fl !== e.fl) begin
                    n_fail++;
                    $display("FAIL phase%0d cyc%0d: got hp=%0d lives=%0d flags=%b, want hp=%0d lives=%0d flags=%b",
                             e.ph, cyc, hp, lives, got_fl, e.hp, e.lv, e.fl);
                end
            end
        end
    end

    initial begin
        // Reset, then idle with a few ignored frame pulses in PLAY.
        phase = 1;
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd16, 3'd3, FL_IDLE);
        idle(10, 5'd16, 3'd3, FL_IDLE);
        step(1, 0, 0, 0, 5'd0, 5'd0, 5'd16, 3'd3, FL_IDLE);

        // Saturation at HP_MAX and netting without intermediate saturation.
        phase = 2;
        step(0, 0, 0, 0, 5'd14, 5'd0, 5'd30, 3'd3, FL_IDLE);
        step(0, 0, 0, 0, 5'd5,  5'd0, 5'd31, 3'd3, FL_IDLE);
        step(0, 0, 0, 0, 5'd3,  5'd5, 5'd29, 3'd3, FL_IDLE);
        step(0, 0, 0, 0, 5'd0,  5'd13, 5'd16, 3'd3, FL_IDLE);

        // Respawn with same-cycle damage; back-to-back respawn and HP ignored in FREEZE.
        phase = 3;
        step(0, 0, 0, 1, 5'd0, 5'd4, 5'd12, 3'd2, FL_RESP);
        step(0, 0, 0, 1, 5'd0, 5'd7, 5'd12, 3'd2, FL_FRZ);
        step(0, 0, 0, 0, 5'd5, 5'd0, 5'd12, 3'd2, FL_FRZ);
        frames(64, 5'd12, 3'd2, FL_FRZ, FL_SHLD);

        // SHIELD: damage and respawn ignored, heal applied, 128 frames to PLAY.
        phase = 4;
        step(0, 0, 0, 1, 5'd0, 5'd10, 5'd12, 3'd2, FL_SHLD);
        step(0, 0, 0, 0, 5'd2, 5'd0,  5'd14, 3'd2, FL_SHLD);
        frames(128, 5'd14, 3'd2, FL_SHLD, FL_IDLE);
        idle(2, 5'd14, 3'd2, FL_IDLE);

        // Second full respawn sequence, then the third goes to GAME_OVER.
        phase = 5;
        step(0, 0, 0, 1, 5'd0, 5'd0, 5'd14, 3'd1, FL_RESP);
        frames(64, 5'd14, 3'd1, FL_FRZ, FL_SHLD);
        frames(128, 5'd14, 3'd1, FL_SHLD, FL_IDLE);
        step(0, 0, 0, 1, 5'd0, 5'd0, 5'd14, 3'd0, FL_GO);
        step(1, 0, 0, 1, 5'd5, 5'd3, 5'd14, 3'd0, FL_GO);
        idle(3, 5'd14, 3'd0, FL_GO);

        // newGame in GAME_OVER overrides same-cycle events.
        phase = 6;
        step(1, 1, 0, 1, 5'd5, 5'd3, 5'd16, 3'd3, FL_IDLE);
        idle(2, 5'd16, 3'd3, FL_IDLE);

        // Respawn that drives HP below zero: clamp to 0, GAME_OVER with lives=2.
        phase = 7;
        step(0, 0, 0, 0, 5'd0, 5'd13, 5'd3, 3'd3, FL_IDLE);
        step(0, 0, 0, 1, 5'd0, 5'd8,  5'd0, 3'd2, FL_GO);
        idle(2, 5'd0, 3'd2, FL_GO);
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd16, 3'd3, FL_IDLE);

        // HP reaching 0 without a collision: GAME_OVER, lives unchanged.
        phase = 8;
        step(0, 0, 0, 0, 5'd0, 5'd31, 5'd0, 3'd3, FL_GO);
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd16, 3'd3, FL_IDLE);

        // newGame mid-FREEZE with a same-cycle frame pulse and heal.
        phase = 9;
        step(0, 0, 0, 1, 5'd0, 5'd0, 5'd16, 3'd2, FL_RESP);
        frames(10, 5'd16, 3'd2, FL_FRZ, FL_FRZ);
        step(1, 1, 0, 0, 5'd4, 5'd0, 5'd16, 3'd3, FL_IDLE);
        idle(3, 5'd16, 3'd3, FL_IDLE);

        // reset mid-SHIELD.
        phase = 10;
        step(0, 0, 0, 1, 5'd0, 5'd2, 5'd14, 3'd2, FL_RESP);
        frames(64, 5'd14, 3'd2, FL_FRZ, FL_SHLD);
        frames(5, 5'd14, 3'd2, FL_SHLD, FL_SHLD);
        step(1, 0, 1, 1, 5'd3, 5'd0, 5'd16, 3'd3, FL_IDLE);
        idle(3, 5'd16, 3'd3, FL_IDLE);

        @(negedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
